// File: rtl/dct_quant_zigzag_if.sv
// Handshake bundle for dct_quant_zigzag: block input side and
// zigzag-ordered quantized coefficient stream side.
interface dct_quant_zigzag_if #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [64*DATA_W-1:0]     y;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic [5:0]               out_zz;
    logic                     out_last;

    modport master (
        output in_valid, y, out_ready,
        input  in_ready, out_valid, out_data, out_zz, out_last
    );

    modport slave (
        input  in_valid, y, out_ready,
        output in_ready, out_valid, out_data, out_zz, out_last
    );
endinterface

// File: rtl/dct_quant_zigzag.sv
// Captures an 8x8 block of Q16.16 DCT coefficients, quantizes with the JPEG
// luminance table via reciprocal multiply, and streams results in zigzag order.
module dct_quant_zigzag #(
    parameter int DATA_W  = 32,
    parameter int OUT_W   = 16,
    parameter int RECIP_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    dct_quant_zigzag_if.slave   bus,
    output logic                ovf
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam int QT [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // product wide enough for |c| * recip plus the rounding carry
    localparam int P_W = DATA_W + RECIP_W + 2;

    localparam logic signed [P_W:0] SMAX =
        {{(P_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [P_W:0] SMIN =
        {{(P_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic [RECIP_W-1:0] recip_rom [64];

    for (genvar k = 0; k < 64; k++) begin : g_recip
        localparam int RV = ((1 << RECIP_W) + QT[k] / 2) / QT[k];
        assign recip_rom[k] = RECIP_W'(RV);
    end

    state_t                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [64*DATA_W-1:0]  blk_q, blk_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_W-1:0]      out_data_q, out_data_d;
    logic [5:0]            out_zz_q, out_zz_d;
    logic                  out_last_q, out_last_d;
    logic                  ovf_q, ovf_d;

    logic [5:0]            raster;
    logic [DATA_W-1:0]     coef;
    logic [DATA_W:0]       mag;
    logic [RECIP_W-1:0]    recip;
    logic [P_W-1:0]        prod;
    logic [P_W-1:0]        qv;
    logic signed [P_W:0]   res;
    logic [OUT_W-1:0]      sat;
    logic                  in_ready;

    always_comb begin
        raster = ZZ[cnt_q];
        coef   = blk_q[raster*DATA_W +: DATA_W];
        recip  = recip_rom[raster];
        // extra magnitude bit keeps the most negative input exact
        mag    = coef[DATA_W-1] ? ({1'b0, ~coef} + (DATA_W+1)'(1))
                                : {1'b0, coef};
        prod   = P_W'(mag) * P_W'(recip);
        qv     = (prod + (P_W'(1) << (15 + RECIP_W))) >> (16 + RECIP_W);
        res    = coef[DATA_W-1] ? -$signed({1'b0, qv}) : $signed({1'b0, qv});
        if (res > SMAX) begin
            sat = SMAX[OUT_W-1:0];
        end else if (res < SMIN) begin
            sat = SMIN[OUT_W-1:0];
        end else begin
            sat = res[OUT_W-1:0];
        end
    end

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_zz_d    = out_zz_q;
        out_last_d  = out_last_q;
        ovf_d       = ovf_q | (bus.in_valid & ~in_ready);
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    blk_d   = bus.y;
                    cnt_d   = 6'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_valid_q & bus.out_ready & out_last_q) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (!out_valid_q | bus.out_ready) begin
                    out_data_d  = sat;
                    out_zz_d    = cnt_q;
                    out_last_d  = (cnt_q == 6'd63);
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zz_q    <= 6'd0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zz_q    <= out_zz_d;
            out_last_q  <= out_last_d;
            ovf_q       <= ovf_d;
        end
    end

    // block buffer is deliberately left out of reset
    always_ff @(posedge clk) begin
        blk_q <= blk_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_zz    = out_zz_q;
    assign bus.out_last  = out_last_q;
    assign ovf           = ovf_q;
endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Bench for dct_quant_zigzag: directed and random blocks against a
// division-based reference with a diagonal-walk zigzag order.
module tb_dct_quant_zigzag;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_quant_zigzag_if #(.DATA_W(32), .OUT_W(16)) a ();
    dct_quant_zigzag_if #(.DATA_W(32), .OUT_W(8))  s ();
    logic ovf_a, ovf_s;

    dct_quant_zigzag #(.DATA_W(32), .OUT_W(16), .RECIP_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(a.slave), .ovf(ovf_a)
    );
    dct_quant_zigzag #(.DATA_W(32), .OUT_W(8), .RECIP_W(16)) u_sat (
        .clk(clk), .rst(rst), .bus(s.slave), .ovf(ovf_s)
    );

    int checks = 0;
    int failures = 0;
    int qt [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };
    int zz [64];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qref(input int c, input int q, input int ow);
        longint mag, r, qq, res, hi, lo;
        mag = (c < 0) ? -longint'(c) : longint'(c);
        r   = ((longint'(1) << 16) + q / 2) / q;
        qq  = (mag * r + (longint'(1) << 31)) >>> 32;
        res = (c < 0) ? -qq : qq;
        hi  = (longint'(1) << (ow - 1)) - 1;
        lo  = -(longint'(1) << (ow - 1));
        if (res > hi) res = hi;
        if (res < lo) res = lo;
        return int'(res);
    endfunction

    function automatic int word(input logic [2047:0] b, input int i);
        return int'(b[i*32 +: 32]);
    endfunction

    task automatic run_block(input logic [2047:0] blk, input int bp_mode,
                             input int ovf_at, input int abort_at);
        int exp [64];
        int n, cyc, hold;
        bit rdy, pv, pr, injected, ovf_seen;
        logic signed [15:0] pd;
        logic [5:0] pz;
        for (int i = 0; i < 64; i++)
            exp[i] = qref(word(blk, zz[i]), qt[zz[i]], 16);
        cyc = 0;
        while (a.in_ready !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        chk("in_ready_idle", 64'(a.in_ready), 64'(1));
        a.y = blk; a.in_valid = 1'b1; a.out_ready = 1'b0;
        @(posedge clk); #1;
        a.in_valid = 1'b0; a.y = ~blk;
        chk("accept_no_beat", 64'(a.out_valid), 64'(0));
        chk("run_busy", 64'(a.in_ready), 64'(0));
        n = 0; cyc = 0; hold = 0; pv = 0; pr = 0; pd = '0; pz = '0;
        injected = 0; ovf_seen = 0;
        while (n < 64 && cyc < 400) begin
            @(posedge clk); #1; cyc++;
            a.in_valid = 1'b0;
            if (cyc == 1) chk("latency", 64'(a.out_valid), 64'(1));
            if (pv && !pr) begin
                chk("hold_valid", 64'(a.out_valid), 64'(1));
                chk("hold_data", 64'(a.out_data), 64'(pd));
                chk("hold_zz", 64'(a.out_zz), 64'(pz));
            end
            if (injected && !ovf_seen) begin
                chk("ovf_set", 64'(ovf_a), 64'(1));
                ovf_seen = 1;
            end
            if (abort_at == n && a.out_valid) begin
                rst = 1'b1; #1;
                chk("abort_valid", 64'(a.out_valid), 64'(0));
                chk("abort_ovf", 64'(ovf_a), 64'(0));
                chk("abort_ready", 64'(a.in_ready), 64'(1));
                @(negedge clk); rst = 1'b0;
                return;
            end
            case (bp_mode)
                1: rdy = !(n == 10 && a.out_valid && hold < 5);
                2: rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            if (bp_mode == 1 && !rdy) hold++;
            a.out_ready = rdy;
            if (ovf_at == n && !injected && a.out_valid) begin
                a.in_valid = 1'b1; injected = 1;
            end
            if (a.out_valid && rdy) begin
                chk("beat_zz", 64'(a.out_zz), 64'(n));
                chk("beat_data", 64'(a.out_data), 64'(exp[n]));
                chk("beat_last", 64'(a.out_last), 64'(n == 63));
                n++;
            end else if (bp_mode == 0) begin
                chk("gap", 64'(a.out_valid), 64'(1));
            end
            pv = a.out_valid; pr = rdy; pd = a.out_data; pz = a.out_zz;
        end
        chk("beats", 64'(n), 64'(64));
        if (bp_mode == 0) chk("cycles", 64'(cyc), 64'(64));
        if (bp_mode == 1) chk("bp_hold_len", 64'(hold), 64'(5));
        @(posedge clk); #1;
        a.in_valid = 1'b0;
        chk("ready_after_last", 64'(a.in_ready), 64'(1));
        chk("valid_cleared", 64'(a.out_valid), 64'(0));
        if (ovf_at >= 0) chk("ovf_sticky", 64'(ovf_a), 64'(1));
    endtask

    task automatic sat_check(input logic [31:0] w, input int expv,
                             input string tag);
        int cyc;
        cyc = 0;
        while (s.in_ready !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        chk({tag, "_ready"}, 64'(s.in_ready), 64'(1));
        s.y = '0; s.y[31:0] = w; s.in_valid = 1'b1;
        @(posedge clk); #1;
        s.in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_valid"}, 64'(s.out_valid), 64'(1));
        chk({tag, "_zz"}, 64'(s.out_zz), 64'(0));
        chk(tag, 64'(s.out_data), 64'(expv));
        chk({tag, "_model"}, 64'(s.out_data), 64'(qref(int'(w), qt[0], 8)));
    endtask

    function automatic logic [2047:0] rand_blk();
        logic [2047:0] b;
        for (int i = 0; i < 64; i++)
            b[i*32 +: 32] = $signed($urandom()) >>> $urandom_range(0, 12);
        return b;
    endfunction

    initial begin
        logic [2047:0] blk, ord;
        int n;
        a.in_valid = 1'b0; a.y = '0; a.out_ready = 1'b0;
        s.in_valid = 1'b0; s.y = '0; s.out_ready = 1'b1;
        n = 0;
        for (int d = 0; d < 15; d++) begin
            int lo, hi;
            lo = (d > 7) ? d - 7 : 0;
            hi = (d < 7) ? d : 7;
            if (d % 2 == 1)
                for (int r = lo; r <= hi; r++) begin zz[n] = r*8 + d - r; n++; end
            else
                for (int r = hi; r >= lo; r--) begin zz[n] = r*8 + d - r; n++; end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(a.out_valid), 64'(0));
        chk("rst_data", 64'(a.out_data), 64'(0));
        chk("rst_zz", 64'(a.out_zz), 64'(0));
        chk("rst_last", 64'(a.out_last), 64'(0));
        chk("rst_ovf", 64'(ovf_a), 64'(0));
        chk("rst_ready", 64'(a.in_ready), 64'(1));
        @(negedge clk); rst = 1'b0;

        blk = '0; blk[31:0] = 32'h0040_0000;
        run_block(blk, 0, -1, -1);

        ord = '0;
        for (int i = 0; i < 64; i++) ord[i*32 +: 32] = qt[i] * i * 65536;
        run_block(ord, 0, -1, -1);

        blk = '0; blk[31:0] = 32'hFFE8_0000; run_block(blk, 0, -1, -1);
        blk = '0; blk[31:0] = 32'h0018_0000; run_block(blk, 0, -1, -1);
        blk = '0; blk[31:0] = 32'h0017_0000; run_block(blk, 0, -1, -1);
        blk = '0; blk[31:0] = 32'hFFF8_0000; run_block(blk, 0, -1, -1);

        run_block(rand_blk(), 1, -1, -1);

        run_block(ord, 0, 5, -1);
        run_block(rand_blk(), 0, -1, 30);
        chk("post_abort_ovf", 64'(ovf_a), 64'(0));
        run_block(ord, 0, -1, -1);

        for (int k = 0; k < 4; k++) run_block(rand_blk(), 2, -1, -1);

        sat_check(32'h7FFF_0000, 127, "sat_pos");
        sat_check(32'h8000_0000, -128, "sat_neg");
        chk("sat_no_ovf", 64'(ovf_s), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
